pixel_write_sink: RTL and testbench
===================================

Name: pixel_write_sink

Overview:
- Receiving end of the plot stream produced by the tower placer and other drawing datapaths: packed coordinates, colour and a plot strobe.
- Buffers plot requests in a small FIFO and clips out-of-range pixels.
- Converts each {x,y} to a linear framebuffer address and drives the VGA framebuffer write port, honouring a grant/stall from that port.
- Sits between the drawing datapaths and the VGA adapter memory.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- SCREEN_W, 160, visible columns; x valid range 0..SCREEN_W-1.
- SCREEN_H, 120, visible rows; y valid range 0..SCREEN_H-1.
- COLOUR_W, 9, colour width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_plot  input  1  plot request strobe.
- in_coordinates  input  15  packed {x[14:7], y[6:0]}.
- in_colour  input  COLOUR_W  pixel colour.
- in_ready  output  1  sink can accept; a request is taken when in_plot && in_ready at a rising edge.
- fb_we  output  1  framebuffer write request.
- fb_addr  output  15  linear address y*SCREEN_W + x.
- fb_data  output  COLOUR_W  colour to write.
- fb_grant  input  1  framebuffer accepts the write this cycle; transfer occurs when fb_we && fb_grant at a rising edge.
- fifo_count  output  clog2(DEPTH)+1  entries currently queued; excludes the output register.
- dropped_count  output  8  number of clipped requests, saturating at 255.
- idle  output  1  high when fifo_count==0 and fb_we==0.

Behaviour:
- Reset (asynchronous, resetn low):
  - FIFO is emptied and the read and write pointers go to 0.
  - fb_we=0, fb_addr=0, fb_data=0, fifo_count=0, dropped_count=0, idle=1, in_ready=1.
  - Requests queued or in flight at reset are discarded; nothing is written for them.
- in_ready:
  - in_ready = (fifo_count != DEPTH), decoded from registered state only.
  - When the FIFO is full, no push occurs even if a pop happens in the same cycle. There is no full-bypass.
- Clipping:
  - An accepted request with x >= SCREEN_W or y >= SCREEN_H is not enqueued.
  - Each such request increments dropped_count by 1, holding at 255.
- Address arithmetic:
  - Computed at enqueue as (y<<7)+(y<<5)+x for the default width, or the generic y*SCREEN_W+x, in 15 bits.
  - Maximum legal address is 19199. The FIFO stores {addr, colour}.
- Output register:
  - The output register (fb_we/fb_addr/fb_data) loads the FIFO head at a rising edge when fb_we==0, or when fb_we && fb_grant, and the FIFO is non-empty. The FIFO pops on that edge.
  - If the FIFO is empty at such an edge, fb_we goes to 0 (or stays 0).
  - While fb_we && !fb_grant, fb_addr and fb_data stay stable and fb_we stays high (stall).
- Latency:
  - A request accepted at edge k into an empty FIFO with fb_we==0 appears with fb_we=1 after edge k+1.
  - With fb_grant held high, sustained throughput is one pixel per clock.
- Simultaneous push and pop: fifo_count is unchanged, and both operations take effect.
- Ordering: pixels are written in acceptance order. Dropped requests do not create gaps or reorder anything.
- Pointers wrap modulo DEPTH. fifo_count never exceeds DEPTH and never underflows.
- Request during stall: an in_plot during a stall is still enqueued if in_ready is high.

Test Plan:
- Reset, then plot x=0,y=0,colour=9'h1FF with fb_grant=1 -> fb_we=1 one cycle after acceptance, fb_addr=0, fb_data=1FF; idle returns to 1 on the following cycle.
- Plot x=159,y=119 -> fb_addr=19199. Plot x=20,y=40 -> fb_addr=6420.
- Plot x=160,y=5, then x=3,y=120 -> no fb_we, dropped_count=2. Then 300 illegal plots -> dropped_count=255.
- fb_grant=0, issue 10 back-to-back legal plots -> in_ready falls after 8 enqueued plus 1 held in the output register; fifo_count=8. Raise fb_grant -> all queued pixels written in order, one per cycle; fb_addr/fb_data stable throughout the stall.
- Continuous plots at full rate with fb_grant toggling 1,0,1,0 -> no loss, no duplication, order preserved, fifo_count consistent.
- Assert resetn low mid-burst with 5 queued -> outputs clear immediately, with no clock edge needed. After release, no stale pixels are written and in_ready=1.

Source files
------------

// File: rtl/pixel_write_sink.sv
// Plot-stream sink: FIFO-buffers pixel requests, clips off-screen ones and
// drives the framebuffer write port with a grant/stall handshake.
module pixel_write_sink #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COLOUR_W = 9
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_plot,
    input  logic [14:0]                in_coordinates,
    input  logic [COLOUR_W-1:0]        in_colour,
    output logic                       in_ready,
    output logic                       fb_we,
    output logic [14:0]                fb_addr,
    output logic [COLOUR_W-1:0]        fb_data,
    input  logic                       fb_grant,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [7:0]                 dropped_count,
    output logic                       idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 15 + COLOUR_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]       r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;
    logic                r_we;
    logic [14:0]         r_addr;
    logic [COLOUR_W-1:0] r_data;
    logic [7:0]          r_dropped;

    logic [7:0]          w_x;
    logic [6:0]          w_y;
    logic [14:0]         w_addr;
    logic                w_accept;
    logic                w_legal;
    logic                w_push;
    logic                w_drop;
    logic                w_load;
    logic                w_empty;
    logic                w_pop;
    logic [EW-1:0]       w_head;

    assign w_x = in_coordinates[14:7];
    assign w_y = in_coordinates[6:0];

    // Shift-add form avoids a multiplier for the default 160-wide screen
    generate
        if (SCREEN_W == 160) begin : g_addr_fast
            assign w_addr = ({8'd0, w_y} << 7) + ({8'd0, w_y} << 5)
                          + {7'd0, w_x};
        end else begin : g_addr_gen
            assign w_addr = 15'(w_y) * 15'(SCREEN_W) + 15'(w_x);
        end
    endgenerate

    assign in_ready = (r_count != FULL);
    assign w_accept = in_plot && in_ready;
    assign w_legal  = (32'(w_x) < SCREEN_W) && (32'(w_y) < SCREEN_H);
    assign w_push   = w_accept && w_legal;
    assign w_drop   = w_accept && !w_legal;

    assign w_empty  = (r_count == '0);
    assign w_load   = !r_we || fb_grant;
    assign w_pop    = w_load && !w_empty;
    assign w_head   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_addr, in_colour};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Output register holds still while the framebuffer stalls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_load) begin
            r_we <= !w_empty;
            if (!w_empty) begin
                r_addr <= w_head[EW-1:COLOUR_W];
                r_data <= w_head[COLOUR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dropped <= '0;
        end else if (w_drop && (r_dropped != 8'hFF)) begin
            r_dropped <= r_dropped + 8'd1;
        end
    end

    assign fb_we         = r_we;
    assign fb_addr       = r_addr;
    assign fb_data       = r_data;
    assign fifo_count    = r_count;
    assign dropped_count = r_dropped;
    assign idle          = w_empty && !r_we;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed bench for pixel_write_sink; a scoreboard queue holds expected
// {addr,colour} words and a negedge monitor checks every framebuffer write.
module tb_pixel_write_sink;

    localparam int DEPTH = 8;
    localparam int SW    = 160;
    localparam int SH    = 120;

    logic        clk;
    logic        resetn;
    logic        in_plot;
    logic [14:0] in_coordinates;
    logic [8:0]  in_colour;
    logic        in_ready;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [8:0]  fb_data;
    logic        fb_grant;
    logic [3:0]  fifo_count;
    logic [7:0]  dropped_count;
    logic        idle;

    int          n_vec;
    int          n_err;
    int          n_acc;
    int          exp_drop;
    logic [23:0] q [$];
    logic        prev_stall;
    logic [23:0] prev_word;

    pixel_write_sink dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_plot        (in_plot),
        .in_coordinates (in_coordinates),
        .in_colour      (in_colour),
        .in_ready       (in_ready),
        .fb_we          (fb_we),
        .fb_addr        (fb_addr),
        .fb_data        (fb_data),
        .fb_grant       (fb_grant),
        .fifo_count     (fifo_count),
        .dropped_count  (dropped_count),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request for one clock; returns 1ns after the edge
    task automatic plot(input int x, input int y, input logic [8:0] c);
        in_plot        = 1'b1;
        in_coordinates = {8'(x), 7'(y)};
        in_colour      = c;
        if (in_ready) begin
            if (x < SW && y < SH) begin
                q.push_back({15'(y * SW + x), c});
                n_acc++;
            end else if (exp_drop < 255) begin
                exp_drop++;
            end
        end
        @(posedge clk);
        #1;
        in_plot = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int cyc);
        cyc = 0;
        while (!idle && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk(tag, 32'(idle), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            chk("count_bound", 32'(fifo_count <= DEPTH), 32'd1);
            if (prev_stall) begin
                chk("stall_we", 32'(fb_we), 32'd1);
                chk("stall_hold", 32'({fb_addr, fb_data}), 32'(prev_word));
            end
            if (fb_we && fb_grant) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL unexpected_write observed=%0h expected=none",
                           {fb_addr, fb_data});
                end else begin
                    chk("write_order", 32'({fb_addr, fb_data}),
                        32'(q.pop_front()));
                end
            end
            prev_stall = fb_we && !fb_grant;
            prev_word  = {fb_addr, fb_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        n_vec = 0; n_err = 0; n_acc = 0; exp_drop = 0;
        prev_stall = 1'b0; prev_word = '0;
        resetn = 1'b0; in_plot = 1'b0; in_coordinates = '0;
        in_colour = '0; fb_grant = 1'b1;
        #1;
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        chk("rst_data", 32'(fb_data), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_drop", 32'(dropped_count), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        plot(0, 0, 9'h1FF);
        chk("lat_pre_we", 32'(fb_we), 32'd0);
        @(posedge clk); #1;
        chk("lat_we", 32'(fb_we), 32'd1);
        chk("lat_addr", 32'(fb_addr), 32'd0);
        chk("lat_data", 32'(fb_data), 32'h1FF);
        chk("lat_busy", 32'(idle), 32'd0);
        @(posedge clk); #1;
        chk("idle_back", 32'(idle), 32'd1);

        plot(159, 119, 9'h055);
        @(posedge clk); #1;
        chk("addr_max", 32'(fb_addr), 32'd19199);
        plot(20, 40, 9'h0AA);
        @(posedge clk); #1;
        chk("addr_mid", 32'(fb_addr), 32'd6420);
        chk("data_mid", 32'(fb_data), 32'h0AA);

        plot(160, 5, 9'h001);
        plot(3, 120, 9'h002);
        @(posedge clk); #1;
        chk("clip_no_we", 32'(fb_we), 32'd0);
        chk("clip_drop2", 32'(dropped_count), 32'd2);
        for (int i = 0; i < 300; i++) begin
            plot(160 + (i % 96), i % 128, 9'(i));
        end
        @(posedge clk); #1;
        chk("clip_sat", 32'(dropped_count), 32'(exp_drop));
        chk("clip_sat_abs", 32'(dropped_count), 32'd255);
        chk("clip_idle", 32'(idle), 32'd1);

        fb_grant = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            plot(10 + i, 50 + i, 9'(16 + i));
        end
        chk("stall_acc", 32'(n_acc), 32'd9);
        chk("stall_full", 32'(fifo_count), 32'd8);
        chk("stall_ready", 32'(in_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1 fb_grant = 1'b1;
        wait_idle("drain_idle", cyc);
        chk("drain_rate", 32'(cyc), 32'd9);
        chk("drain_sb", 32'(q.size()), 32'd0);

        for (int i = 0; i < 30; i++) begin
            fb_grant = (i % 2 == 0);
            plot($urandom_range(0, SW - 1), $urandom_range(0, SH - 1),
                 9'($urandom_range(0, 511)));
        end
        fb_grant = 1'b1;
        wait_idle("toggle_idle", cyc);
        chk("toggle_sb", 32'(q.size()), 32'd0);

        fb_grant = 1'b0;
        for (int i = 0; i < 6; i++) begin
            plot(100 + i, 7 * i, 9'(300 + i));
        end
        chk("pre_rst_count", 32'(fifo_count), 32'd5);
        chk("pre_rst_we", 32'(fb_we), 32'd1);
        #2 resetn = 1'b0;
        q.delete();
        exp_drop = 0;
        #1;
        chk("arst_we", 32'(fb_we), 32'd0);
        chk("arst_addr", 32'(fb_addr), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_drop", 32'(dropped_count), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_idle", 32'(idle), 32'd1);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        fb_grant = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_we", 32'(fb_we), 32'd0);
        chk("post_ready", 32'(in_ready), 32'd1);
        chk("post_idle", 32'(idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
